demux32_buf: RTL and testbench
==============================

Name: demux32_buf

Overview:
- 1-to-8 32-bit demultiplexer with registered holding slots: the write-side counterpart of the 3-bit-select 8-way word selector in the datapath.
- An incoming word is steered by `choose` into one of 8 output slots.
- Each slot holds its word with a valid flag until the consumer on that channel acknowledges it.
- Used where one producer (e.g. writeback or bus return path) feeds up to 8 independent consumers.

Parameters:
- WIDTH, 32, data width of each slot.
- NCH, 8, number of output channels; fixed at 8, `choose` is 3 bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low: reset==0 at a rising edge clears state.
- in_valid  input  1  producer presents in_data/choose this cycle.
- in_ready  output  1  block accepts this cycle; transfer occurs when in_valid && in_ready.
- choose  input  3  destination channel index 0..7.
- in_data  input  32  word to deliver.
- out_valid  output  8  bit i = slot i holds an unconsumed word.
- out_data0 .. out_data7  output  32 each  slot i contents.
- out_ack  input  8  bit i = consumer i takes slot i this cycle.
- occupancy  output  4  registered count of set out_valid bits, 0..8.

Behaviour:
- **Reset**
  - While reset==0 at a clock edge: all out_dataN <= 0, out_valid <= 0, occupancy <= 0.
  - While reset==0, in_ready is forced to 0, and in_valid and out_ack are ignored.
  - Reset mid-operation discards all held words; there is no partial state.
- **in_ready**
  - Combinational: in_ready = reset && (!out_valid[choose] || out_ack[choose]).
  - A full slot being acked in the same cycle accepts new data (pass-through, no bubble).
  - in_ready depends only on the selected slot; other full slots never stall.
- **Accept**
  - On in_valid && in_ready: out_data[choose] <= in_data; out_valid[choose] <= 1.
  - Latency 1 cycle: the word is visible on out_dataN and out_valid[N] the cycle after acceptance.
- **Ack**
  - out_ack[i] && out_valid[i]: out_valid[i] <= 0 unless the same cycle accepts into slot i, in which case it stays 1 with new data.
  - out_ack[i] with out_valid[i]==0 is ignored; there is no state change and no error.
  - Multiple acks in one cycle are all honoured independently.
- **Data retention**
  - out_dataN is held after ack (stale value, valid low).
  - out_dataN changes only on acceptance into slot N.
- **Stall**
  - in_valid && !in_ready: nothing written.
  - The producer must hold in_data/choose stable until accepted.
  - The block does not check stability; behaviour under changing choose is defined per-cycle by the rule above.
- **Occupancy**
  - occupancy <= popcount of next-state out_valid, so it always equals popcount(out_valid) in the same cycle.
  - Range 0..8; it cannot overflow because each slot holds at most one word.
- **Simultaneous events** (same cycle, slot i):
  - full + ack + accept: replace, valid stays 1, occupancy unchanged.
  - empty + accept + ack: ack ignored, valid becomes 1.
- There is no internal FSM beyond the per-slot valid bits; each slot is a 2-state (EMPTY/FULL) machine:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on ack without accept.
  - FULL -> FULL on accept with ack (replace).

Test Plan:
1. Reset: hold reset=0 for 2 cycles with in_valid=1, choose=3, out_ack=8'hFF -> out_valid=0, all out_dataN=0, occupancy=0, in_ready=0 throughout.
2. Fill all: reset=1; write 32'h1000_000N to choose=N for N=0..7 on consecutive cycles, no acks -> out_valid=8'hFF, occupancy=8, out_data5=32'h1000_0005; next in_valid with choose=2 -> in_ready=0, out_data2 unchanged.
3. Pass-through: slot 2 full with 32'hAAAA_AAAA; same cycle out_ack=8'h04, in_valid=1, choose=2, in_data=32'h5555_5555 -> in_ready=1; next cycle out_valid[2]=1, out_data2=32'h5555_5555, occupancy unchanged.
4. Ack on empty: all slots empty, out_ack=8'hFF -> no change, occupancy=0; then write 32'hDEAD_BEEF to choose=7 while out_ack[7]=1 -> out_valid=8'h80, occupancy=1.
5. Multi-ack: slots 0,1,4 full; out_ack=8'h13 -> next cycle out_valid=0, occupancy=0, out_data0/1/4 still hold their old values.
6. Reset mid-stream: slots 0..3 full, assert reset=0 for one cycle during an accept to choose=6 -> out_valid=0, occupancy=0, out_data6=0.

Source files
------------

// File: rtl/demux32_buf_if.sv
// Producer/consumer bundle for demux32_buf: one write port steered by choose,
// eight held output slots with per-slot valid/ack.
interface demux32_buf_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       choose;
    logic [WIDTH-1:0] in_data;
    logic [NCH-1:0]   out_valid;
    logic [NCH-1:0]   out_ack;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [WIDTH-1:0] out_data4;
    logic [WIDTH-1:0] out_data5;
    logic [WIDTH-1:0] out_data6;
    logic [WIDTH-1:0] out_data7;
    logic [3:0]       occupancy;

    // Producer and consumers together drive the block from this side.
    modport master (
        output in_valid, choose, in_data, out_ack,
        input  in_ready, out_valid, occupancy,
        input  out_data0, out_data1, out_data2, out_data3,
        input  out_data4, out_data5, out_data6, out_data7
    );

    modport slave (
        input  in_valid, choose, in_data, out_ack,
        output in_ready, out_valid, occupancy,
        output out_data0, out_data1, out_data2, out_data3,
        output out_data4, out_data5, out_data6, out_data7
    );
endinterface

// File: rtl/demux32_buf.sv
// 1-to-8 word demultiplexer with a registered holding slot per channel.
// Each slot is an EMPTY/FULL bit; a full slot acked this cycle may be refilled without a bubble.
module demux32_buf #(
    parameter int WIDTH = 32,
    parameter int NCH   = 8
) (
    input  logic          clk,
    input  logic          reset,
    demux32_buf_if.slave  bus
);
    logic [NCH-1:0]   r_valid;
    logic [WIDTH-1:0] r_data [NCH];
    logic [3:0]       r_occupancy;

    logic             w_in_ready;
    logic             w_accept;
    logic [NCH-1:0]   w_wr_en;
    logic [NCH-1:0]   w_valid_nxt;
    logic [3:0]       w_occ_nxt;

    always_comb begin
        // NOTE: every signal gets a value before any conditional logic, so no latch can be inferred.
        w_wr_en   = '0;
        w_occ_nxt = '0;

        // Only the addressed slot can stall the producer.
        w_in_ready = reset && (!r_valid[bus.choose] || bus.out_ack[bus.choose]);
        w_accept   = bus.in_valid && w_in_ready;

        for (int i = 0; i < NCH; i++) begin
            if (w_accept && (bus.choose == 3'(i))) begin
                w_wr_en[i] = 1'b1;
            end
        end

        // Acks on empty slots clear nothing; a same-cycle write wins over an ack.
        w_valid_nxt = (r_valid & ~bus.out_ack) | w_wr_en;

        for (int i = 0; i < NCH; i++) begin
            w_occ_nxt = w_occ_nxt + 4'(w_valid_nxt[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid     <= '0;
            r_occupancy <= '0;
            // NOTE: slot storage is cleared on reset because held words are directly visible on out_dataN.
            for (int i = 0; i < NCH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid     <= w_valid_nxt;
            r_occupancy <= w_occ_nxt;
            for (int i = 0; i < NCH; i++) begin
                if (w_wr_en[i]) begin
                    r_data[i] <= bus.in_data;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.occupancy = r_occupancy;
    assign bus.out_data0 = r_data[0];
    assign bus.out_data1 = r_data[1];
    assign bus.out_data2 = r_data[2];
    assign bus.out_data3 = r_data[3];
    assign bus.out_data4 = r_data[4];
    assign bus.out_data5 = r_data[5];
    assign bus.out_data6 = r_data[6];
    assign bus.out_data7 = r_data[7];
endmodule

// File: tb/tb_demux32_buf.sv
// Directed bench for demux32_buf: reset, fill, pass-through, idle acks,
// multi-ack and mid-stream reset, each with hand-computed expectations.
module tb_demux32_buf;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    demux32_buf_if #(.WIDTH(32), .NCH(8)) u_if ();

    demux32_buf #(.WIDTH(32), .NCH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slot(input int idx);
        case (idx)
            0: slot = u_if.out_data0;
            1: slot = u_if.out_data1;
            2: slot = u_if.out_data2;
            3: slot = u_if.out_data3;
            4: slot = u_if.out_data4;
            5: slot = u_if.out_data5;
            6: slot = u_if.out_data6;
            default: slot = u_if.out_data7;
        endcase
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // 1. Reset with active-looking inputs that must be ignored.
        reset          = 1'b0;
        u_if.in_valid  = 1'b1;
        u_if.choose    = 3'd3;
        u_if.in_data   = 32'h1234_5678;
        u_if.out_ack   = 8'hFF;
        #1;
        check("rst_ready0", 32'(u_if.in_ready), 32'd0);
        tick;
        check("rst_ready1", 32'(u_if.in_ready), 32'd0);
        check("rst_valid1", 32'(u_if.out_valid), 32'h0);
        tick;
        check("rst_ready2", 32'(u_if.in_ready), 32'd0);
        check("rst_valid2", 32'(u_if.out_valid), 32'h0);
        check("rst_occ", 32'(u_if.occupancy), 32'd0);
        for (int n = 0; n < 8; n++) begin
            check($sformatf("rst_data%0d", n), slot(n), 32'h0);
        end

        // 2. Fill every slot in consecutive cycles without acks.
        reset        = 1'b1;
        u_if.out_ack = 8'h00;
        for (int n = 0; n < 8; n++) begin
            u_if.in_valid = 1'b1;
            u_if.choose   = 3'(n);
            u_if.in_data  = 32'h1000_0000 | 32'(n);
            #1;
            check($sformatf("fill_ready%0d", n), 32'(u_if.in_ready), 32'd1);
            tick;
            check($sformatf("fill_occ%0d", n), 32'(u_if.occupancy), 32'(n + 1));
        end
        u_if.in_valid = 1'b0;
        check("fill_valid", 32'(u_if.out_valid), 32'hFF);
        check("fill_occ", 32'(u_if.occupancy), 32'd8);
        check("fill_data5", u_if.out_data5, 32'h1000_0005);
        u_if.in_valid = 1'b1;
        u_if.choose   = 3'd2;
        u_if.in_data  = 32'hFFFF_0002;
        #1;
        check("stall_ready", 32'(u_if.in_ready), 32'd0);
        tick;
        check("stall_data2", u_if.out_data2, 32'h1000_0002);
        check("stall_valid", 32'(u_if.out_valid), 32'hFF);

        // 3. Pass-through: replace a full slot while it is acked.
        u_if.out_ack = 8'h04;
        u_if.in_data = 32'hAAAA_AAAA;
        #1;
        check("pt_ready_a", 32'(u_if.in_ready), 32'd1);
        tick;
        check("pt_data2_a", u_if.out_data2, 32'hAAAA_AAAA);
        u_if.in_data = 32'h5555_5555;
        #1;
        check("pt_ready_b", 32'(u_if.in_ready), 32'd1);
        tick;
        check("pt_valid", 32'(u_if.out_valid), 32'hFF);
        check("pt_data2_b", u_if.out_data2, 32'h5555_5555);
        check("pt_occ", 32'(u_if.occupancy), 32'd8);

        // 4. Drain all, then acks on empty slots, then write with a same-cycle ack.
        u_if.in_valid = 1'b0;
        u_if.out_ack  = 8'hFF;
        tick;
        check("drain_valid", 32'(u_if.out_valid), 32'h0);
        check("drain_occ", 32'(u_if.occupancy), 32'd0);
        tick;
        check("idle_ack_valid", 32'(u_if.out_valid), 32'h0);
        check("idle_ack_occ", 32'(u_if.occupancy), 32'd0);
        check("retain_data3", u_if.out_data3, 32'h1000_0003);
        u_if.in_valid = 1'b1;
        u_if.choose   = 3'd7;
        u_if.in_data  = 32'hDEAD_BEEF;
        u_if.out_ack  = 8'h80;
        #1;
        check("ea_ready", 32'(u_if.in_ready), 32'd1);
        tick;
        check("ea_valid", 32'(u_if.out_valid), 32'h80);
        check("ea_occ", 32'(u_if.occupancy), 32'd1);
        check("ea_data7", u_if.out_data7, 32'hDEAD_BEEF);

        // Clear slot 7 before the multi-ack case.
        u_if.in_valid = 1'b0;
        u_if.out_ack  = 8'hFF;
        tick;
        u_if.out_ack  = 8'h00;

        // 5. Fill slots 0, 1, 4 then ack them together.
        u_if.in_valid = 1'b1;
        u_if.choose   = 3'd0;
        u_if.in_data  = 32'h0000_0011;
        tick;
        u_if.choose   = 3'd1;
        u_if.in_data  = 32'h0000_0022;
        #1;
        check("other_full_ready", 32'(u_if.in_ready), 32'd1);
        tick;
        u_if.choose   = 3'd4;
        u_if.in_data  = 32'h0000_0044;
        tick;
        u_if.in_valid = 1'b0;
        check("ma_pre_valid", 32'(u_if.out_valid), 32'h13);
        check("ma_pre_occ", 32'(u_if.occupancy), 32'd3);
        u_if.out_ack  = 8'h13;
        tick;
        u_if.out_ack  = 8'h00;
        check("ma_valid", 32'(u_if.out_valid), 32'h0);
        check("ma_occ", 32'(u_if.occupancy), 32'd0);
        check("ma_data0", u_if.out_data0, 32'h0000_0011);
        check("ma_data1", u_if.out_data1, 32'h0000_0022);
        check("ma_data4", u_if.out_data4, 32'h0000_0044);

        // 6. Reset mid-stream during an attempted accept.
        u_if.in_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            u_if.choose  = 3'(n);
            u_if.in_data = 32'h6000_0000 | 32'(n);
            tick;
        end
        check("mr_pre_occ", 32'(u_if.occupancy), 32'd4);
        check("mr_pre_valid", 32'(u_if.out_valid), 32'h0F);
        reset        = 1'b0;
        u_if.choose  = 3'd6;
        u_if.in_data = 32'h6666_6666;
        #1;
        check("mr_ready", 32'(u_if.in_ready), 32'd0);
        tick;
        check("mr_valid", 32'(u_if.out_valid), 32'h0);
        check("mr_occ", 32'(u_if.occupancy), 32'd0);
        check("mr_data6", u_if.out_data6, 32'h0);
        check("mr_data0", u_if.out_data0, 32'h0);
        reset = 1'b1;
        #1;
        check("post_rst_ready", 32'(u_if.in_ready), 32'd1);
        tick;
        u_if.in_valid = 1'b0;
        check("post_rst_valid", 32'(u_if.out_valid), 32'h40);
        check("post_rst_data6", u_if.out_data6, 32'h6666_6666);
        check("post_rst_occ", 32'(u_if.occupancy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
